// File: rtl/acc_pkg.sv
// acc_pkg: op codes, op width and multiplier FSM state encoding shared by acc_bank and acc_mul_seq
package acc_pkg;
  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OP_W-1:0] OP_LOAD = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
  localparam logic [OP_W-1:0] OP_AND  = 4'd4;
  localparam logic [OP_W-1:0] OP_OR   = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd7;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd8;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd9;
  localparam logic [OP_W-1:0] OP_CLR  = 4'd10;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WB} mul_st_t;
endpackage

// File: rtl/acc_mul_seq.sv
// acc_mul_seq: shift-add multiplier, one partial product per cycle
// Ports: clk, rst_n (async active-low), start (accepted only in IDLE), multiplicand, multiplier,
//        busy (RUN..WB), done (one-cycle pulse after writeback), wb (writeback cycle), product (2*WIDTH)
module acc_mul_seq
  import acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic               wb,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  mul_st_t st;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0] cnt;
  assign wb = st == ST_WB;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= ST_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      mcand <= '0;
      mplier <= '0;
      product <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        ST_IDLE:
          if (start) begin
            mcand <= {{WIDTH{1'b0}}, multiplicand};
            mplier <= multiplier;
            product <= '0;
            cnt <= '0;
            busy <= 1'b1;
            st <= ST_RUN;
          end
        ST_RUN: begin
          if (mplier[0]) product <= product + mcand;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) st <= ST_WB;
        end
        ST_WB: begin
          busy <= 1'b0;
          done <= 1'b1;
          st <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
endmodule

// File: rtl/acc_bank.sv
// acc_bank: DEPTH accumulators with single-cycle ALU, Z/C/N/V flags and a sequential multiply
// Ports: clk, rst_n (async active-low), en (issue when not busy), op, sel, in (operand B),
//        out (acc[sel], combinational), z_out/c_out/n_out/v_out, busy, done
// Option: define ACC_SAT_EN for signed saturation of ADD/SUB results
module acc_bank
  import acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [OP_W-1:0]  op,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             z_out,
  output logic             c_out,
  output logic             n_out,
  output logic             v_out,
  output logic             busy,
  output logic             done
);
  logic [WIDTH-1:0] acc [DEPTH];
  logic [SEL_W-1:0] idx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] a, res, add_r, sub_r;
  logic [WIDTH:0] sum, diff;
  logic accept, start, wb, wr, c, v, ovf_add, ovf_sub;
  assign a = acc[sel];
  assign out = a;
  assign accept = en & ~busy;
  assign start = accept && op == OP_MUL;
  assign sum = {1'b0, a} + {1'b0, in};
  assign diff = {1'b0, a} - {1'b0, in};
  assign ovf_add = a[WIDTH-1] == in[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
  assign ovf_sub = a[WIDTH-1] != in[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1];
`ifdef ACC_SAT_EN
  logic [WIDTH-1:0] sat;
  // the sign of a always gives the overflow direction for both ADD and SUB
  assign sat = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign add_r = ovf_add ? sat : sum[WIDTH-1:0];
  assign sub_r = ovf_sub ? sat : diff[WIDTH-1:0];
`else
  assign add_r = sum[WIDTH-1:0];
  assign sub_r = diff[WIDTH-1:0];
`endif
  always_comb begin
    res = a;
    c = 1'b0;
    v = 1'b0;
    wr = 1'b1;
    case (op)
      OP_LOAD: res = in;
      OP_ADD: begin
        res = add_r;
        c = sum[WIDTH];
        v = ovf_add;
      end
      OP_SUB: begin
        res = sub_r;
        c = diff[WIDTH];
        v = ovf_sub;
      end
      OP_AND: res = a & in;
      OP_OR: res = a | in;
      OP_XOR: res = a ^ in;
      OP_SHL: begin
        res = a << 1;
        c = a[WIDTH-1];
      end
      OP_SHR: begin
        res = a >> 1;
        c = a[0];
      end
      OP_CLR: res = '0;
      default: wr = 1'b0;
    endcase
  end
  acc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .multiplicand(a),
    .multiplier(in),
    .busy(busy),
    .done(done),
    .wb(wb),
    .product(prod)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
      idx <= '0;
      z_out <= 1'b0;
      c_out <= 1'b0;
      n_out <= 1'b0;
      v_out <= 1'b0;
    end else begin
      if (start) idx <= sel;
      if (wb) begin
        acc[idx] <= prod[WIDTH-1:0];
        z_out <= prod[WIDTH-1:0] == '0;
        c_out <= |prod[2*WIDTH-1:WIDTH];
        n_out <= prod[WIDTH-1];
        v_out <= 1'b0;
      end else if (accept && wr) begin
        acc[sel] <= res;
        z_out <= res == '0;
        c_out <= c;
        n_out <= res[WIDTH-1];
        v_out <= v;
      end
    end
endmodule

// File: tb/tb_acc_bank.sv
// tb_acc_bank: scoreboard bench for acc_bank (WIDTH=8, DEPTH=4)
module tb_acc_bank;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [3:0] op = '0;
  logic [1:0] sel = '0;
  logic [7:0] in = '0;
  logic [7:0] out;
  logic z_out, c_out, n_out, v_out, busy, done;
  typedef struct packed {logic [1:0] s; logic [7:0] v; logic [3:0] f;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int m_acc[4];
  logic [3:0] m_f = '0;
  acc_bank #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .sel(sel), .in(in), .out(out),
    .z_out(z_out), .c_out(c_out), .n_out(n_out), .v_out(v_out), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic void model(int o, int s, int b);
    int a = m_acc[s];
    int r = 0, sa, sbv, sr = 0;
    logic c = 1'b0, v = 1'b0;
    sa = a > 127 ? a - 256 : a;
    sbv = b > 127 ? b - 256 : b;
    case (o)
      1: r = b;
      2: begin r = a + b; c = r > 255; sr = sa + sbv; v = sr > 127 || sr < -128; end
      3: begin r = a - b; c = a < b; sr = sa - sbv; v = sr > 127 || sr < -128; end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: begin r = a << 1; c = a >= 128; end
      8: begin r = a >> 1; c = (a & 1) == 1; end
      9: begin r = a * b; c = r > 255; end
      10: r = 0;
      default: return;
    endcase
`ifdef ACC_SAT_EN
    if (v && (o == 2 || o == 3)) r = sr > 127 ? 127 : 128;
`endif
    r = r & 255;
    m_acc[s] = r;
    m_f = {r == 0, c, r >= 128, v};
  endfunction
  task automatic push(int s);
    exp_t e;
    e.s = 2'(s);
    e.v = 8'(m_acc[s]);
    e.f = m_f;
    sb.push_back(e);
  endtask
  task automatic pop_check(string tag);
    exp_t e;
    if (sb.size() == 0) check({tag, " sb_empty"}, 1, 0);
    else begin
      e = sb.pop_front();
      sel = e.s;
      #1;
      check({tag, " out"}, out, e.v);
      check({tag, " flags"}, {z_out, c_out, n_out, v_out}, e.f);
    end
  endtask
  task automatic read_check(int s, string tag);
    sel = 2'(s);
    #1;
    check(tag, out, m_acc[s]);
  endtask
  task automatic issue(int o, int s, int b, string tag);
    op = 4'(o);
    sel = 2'(s);
    in = 8'(b);
    en = 1'b1;
    model(o, s, b);
    push(s);
    @(posedge clk);
    #1;
    en = 1'b0;
    pop_check(tag);
  endtask
  task automatic mul_run(int s, int b, string tag, bit poke);
    int bc = 0;
    op = 4'd9;
    sel = 2'(s);
    in = 8'(b);
    en = 1'b1;
    model(9, s, b);
    push(s);
    @(posedge clk);
    #1;
    en = 1'b0;
    sel = 2'd0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (busy) bc++;
      if (poke && k == 2) begin op = 4'd2; in = 8'h05; en = 1'b1; end
      if (poke && k == 3) en = 1'b0;
      @(posedge clk);
      #1;
    end
    en = 1'b0;
    check({tag, " busy_cycles"}, bc, 9);
    check({tag, " done"}, done, 1);
    check({tag, " busy_at_done"}, busy, 0);
    pop_check(tag);
    @(posedge clk);
    #1;
    check({tag, " done_once"}, done, 0);
    read_check(0, {tag, " acc0"});
  endtask
  initial begin
    int dn;
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) read_check(i, "reset out");
    check("reset flags", {z_out, c_out, n_out, v_out}, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    issue(1, 1, 8'hFF, "load ff");
    issue(2, 1, 8'h01, "add wrap");
    check("add wrap value", out, 8'h00);
    check("add wrap flags", {z_out, c_out, n_out, v_out}, 4'b1100);
    read_check(0, "untouched acc0");
    read_check(2, "untouched acc2");
    read_check(3, "untouched acc3");
    issue(1, 2, 8'h80, "load 80");
    issue(3, 2, 8'h01, "sub ovf");
`ifdef ACC_SAT_EN
    check("sub sat value", out, 8'h80);
    check("sub sat flags", {z_out, c_out, n_out, v_out}, 4'b0011);
`else
    check("sub wrap value", out, 8'h7F);
    check("sub wrap flags", {z_out, c_out, n_out, v_out}, 4'b0001);
`endif
    issue(1, 3, 8'h12, "load 12");
    mul_run(3, 8'h10, "mul", 1'b1);
    read_check(3, "mul acc3");
    check("mul acc3 value", out, 8'h20);
    issue(1, 2, 8'h81, "load 81");
    issue(7, 2, 0, "shl");
    check("shl flags", {z_out, c_out, n_out, v_out}, 4'b0100);
    issue(1, 1, 8'h01, "load 01");
    issue(8, 1, 0, "shr");
    check("shr flags", {z_out, c_out, n_out, v_out}, 4'b1100);
    issue(13, 1, 8'h55, "reserved op");
    issue(0, 2, 8'h55, "nop");
    for (int i = 0; i < 24; i++) begin
      int o = $urandom_range(0, 15);
      issue(o == 9 ? 1 : o, $urandom_range(0, 3), $urandom_range(0, 255), "rand op");
    end
    for (int i = 0; i < 3; i++) mul_run($urandom_range(0, 3), $urandom_range(0, 255), "rand mul", 1'b0);
    issue(1, 1, 8'h0F, "load 0f");
    op = 4'd9;
    sel = 2'd1;
    in = 8'h0F;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("abort busy before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 0;
      read_check(i, "abort acc");
    end
    check("abort flags", {z_out, c_out, n_out, v_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      dn += int'(done);
    end
    check("abort no done", dn, 0);
    read_check(1, "abort acc1 after");
    check("sb drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
